// File: rtl/jedro_1_ifu_prefetch.sv
// Instruction fetch unit: prefetch FIFO, multiple outstanding in-order reads, jump flush/discard.
// Optional macro JEDRO_1_IFU_MISALIGN_EXC_EN adds misaligned_o and stalls fetch on unaligned jumps.
module jedro_1_ifu_prefetch #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  decoder_ready_i,
    input  logic                  jmp_instr_i,
    input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
`ifdef JEDRO_1_IFU_MISALIGN_EXC_EN
    output logic                  misaligned_o,
`endif
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic                  instr_valid_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ADDR_WIDTH-1:0] STEP_A     = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(STEP_A - 1'b1);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [OUT_W-1:0]      out_q, out_d;
    logic [OUT_W-1:0]      disc_q, disc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;

    logic [ADDR_WIDTH-1:0] jmp_tgt;
    logic fetch_hold;
    logic issue_ok, issue, push, pop, drop, valid;

    assign jmp_tgt = jmp_addr_i & ALIGN_MASK;

`ifdef JEDRO_1_IFU_MISALIGN_EXC_EN
    logic mis_q, mis_d;

    always_comb begin
        mis_d = mis_q;
        if (jmp_instr_i) mis_d = |(jmp_addr_i & ~ALIGN_MASK);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) mis_q <= 1'b0;
        else       mis_q <= mis_d;
    end

    assign fetch_hold   = mis_q;
    assign misaligned_o = mis_q;
`else
    assign fetch_hold = 1'b0;
`endif

    // Fetch budget counts in-flight reads so every response always has a FIFO slot.
    assign issue_ok  = ((32'(cnt_q) + 32'(out_q)) < FIFO_DEPTH) && (32'(out_q) < MAX_OUTSTANDING);
    assign mem_req_o = !rst_i && !jmp_instr_i && !fetch_hold && issue_ok;
    assign mem_addr_o = pc_q;
    assign issue = mem_req_o && mem_gnt_i;

    assign valid = (cnt_q != '0);
    assign pop   = valid && decoder_ready_i && !jmp_instr_i;
    assign drop  = mem_rvalid_i && (disc_q != '0);
    assign push  = mem_rvalid_i && (disc_q == '0) && !jmp_instr_i;

    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        out_d    = out_q + OUT_W'(issue) - OUT_W'(mem_rvalid_i);
        disc_d   = disc_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        data_d   = data_q;
        addr_d   = addr_q;

        if (issue) pc_d = pc_q + STEP_A;
        if (drop)  disc_d = disc_q - 1'b1;
        if (push) begin
            data_d[wr_ptr_q] = mem_rdata_i;
            addr_d[wr_ptr_q] = rsp_pc_q;
            rsp_pc_d         = rsp_pc_q + STEP_A;
        end

        // Everything still in flight after this cycle belongs to the old stream.
        if (jmp_instr_i) begin
            pc_d     = jmp_tgt;
            rsp_pc_d = jmp_tgt;
            disc_d   = out_d;
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q     <= BOOT_ADDR;
            rsp_pc_q <= BOOT_ADDR;
            out_q    <= '0;
            disc_q   <= '0;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            disc_q   <= disc_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        data_q <= data_d;
        addr_q <= addr_d;
    end

    assign instr_valid_o = valid;
    assign instr_o       = valid ? data_q[rd_ptr_q] : '0;
    assign instr_addr_o  = valid ? addr_q[rd_ptr_q] : '0;

endmodule
